// File: rtl/srio_swrite_hello_gen.sv
// SRIO SWRITE packetizer: buffers up to MAX_WORDS payload words, then emits a
// HELLO-format header beat followed by the buffered payload on the output stream.
module srio_swrite_hello_gen #(
    parameter int MAX_WORDS = 32
) (
    input  logic        AXIS_ACLK,
    input  logic        AXIS_ARESETN,
    input  logic [63:0] S_AXIS_TDATA,
    input  logic        S_AXIS_TLAST,
    input  logic        S_AXIS_TVALID,
    output logic        S_AXIS_TREADY,
    input  logic [31:0] S_AXIS_TUSER,
    output logic [63:0] M_AXIS_TDATA,
    output logic        M_AXIS_TLAST,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic [31:0] M_AXIS_TUSER,
    input  logic [31:0] cmd,
    input  logic [33:0] base_addr,
    input  logic [31:0] hdr_cfg,
    output logic [31:0] status
);
    localparam int PW = 5;
    localparam int CW = 6;
    localparam logic [CW-1:0] LAST_IDX = CW'(MAX_WORDS - 1);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [63:0]   r_buf [0:MAX_WORDS-1];
    logic [63:0]   r_rd_word;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_rd_ptr;
    logic [33:0]   r_offset;
    logic [7:0]    r_tid;
    logic [15:0]   r_pkt_cnt;
    logic          r_ovf;
    logic [31:0]   r_tuser;

    logic          w_srst;
    logic          w_in_fire;
    logic          w_out_fire;
    logic          w_last_beat;
    logic [PW-1:0] w_rd_addr;
    logic [7:0]    w_size;
    logic [33:0]   w_addr;
    logic [63:0]   w_header;
    logic          w_unused_bits;

    assign w_srst        = ~AXIS_ARESETN | cmd[1];
    assign S_AXIS_TREADY = (r_state == S_FILL) & cmd[0] & ~cmd[1];
    assign M_AXIS_TVALID = (r_state != S_FILL);
    assign M_AXIS_TUSER  = r_tuser;
    assign w_in_fire     = S_AXIS_TVALID & S_AXIS_TREADY;
    assign w_out_fire    = M_AXIS_TVALID & M_AXIS_TREADY;
    assign w_last_beat   = ({1'b0, r_rd_ptr} == (r_cnt - CW'(1)));

    // A full 32-word packet has r_cnt[4:0]==0, so the 8-bit wrap yields 0xFF.
    assign w_size   = {r_cnt[4:0], 3'b000} - 8'd1;
    assign w_addr   = base_addr + r_offset;
    assign w_header = {r_tid, 4'h6, 4'h0, 1'b0, hdr_cfg[9:8], hdr_cfg[10],
                       w_size, 2'b00, w_addr};

    assign status        = {14'd0, (r_state != S_FILL), r_ovf, r_pkt_cnt};
    assign w_unused_bits = ^{cmd[31:2], hdr_cfg[31:11]};

    always_ff @(posedge AXIS_ACLK) begin
        if (w_srst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rd_addr    = '0;
        M_AXIS_TDATA = '0;
        M_AXIS_TLAST = 1'b0;
        case (r_state)
            S_FILL: begin
                if (w_in_fire && (S_AXIS_TLAST || (r_cnt == LAST_IDX))) begin
                    w_state_next = S_HDR;
                end
            end
            S_HDR: begin
                M_AXIS_TDATA = w_header;
                if (M_AXIS_TREADY) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                M_AXIS_TDATA = r_rd_word;
                M_AXIS_TLAST = w_last_beat;
                // Prefetch the word that will be presented after this edge.
                w_rd_addr    = w_out_fire ? (r_rd_ptr + PW'(1)) : r_rd_ptr;
                if (w_out_fire && w_last_beat) begin
                    w_state_next = S_FILL;
                end
            end
            default: w_state_next = S_FILL;
        endcase
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (w_in_fire) begin
            r_buf[r_cnt[PW-1:0]] <= S_AXIS_TDATA;
        end
        r_rd_word <= r_buf[w_rd_addr];
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (w_srst) begin
            r_cnt     <= '0;
            r_rd_ptr  <= '0;
            r_offset  <= '0;
            r_tid     <= hdr_cfg[7:0];
            r_pkt_cnt <= '0;
            r_ovf     <= 1'b0;
            r_tuser   <= '0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_in_fire) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == '0) begin
                            r_tuser <= S_AXIS_TUSER;
                        end
                        if ((r_cnt == LAST_IDX) && !S_AXIS_TLAST) begin
                            r_ovf <= 1'b1;
                        end
                    end
                end
                S_HDR: begin
                    if (w_out_fire) begin
                        r_rd_ptr <= '0;
                    end
                end
                S_DATA: begin
                    if (w_out_fire) begin
                        r_rd_ptr <= r_rd_ptr + PW'(1);
                        if (w_last_beat) begin
                            r_cnt     <= '0;
                            r_offset  <= r_offset + {25'd0, r_cnt, 3'b000};
                            r_tid     <= r_tid + 8'd1;
                            r_pkt_cnt <= r_pkt_cnt + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_srio_swrite_hello_gen.sv
// Randomized bench for srio_swrite_hello_gen: a queue-based packet model predicts
// every output beat, ready and status each cycle; literal headers pin the model.
module tb_srio_swrite_hello_gen;
    localparam int MAXW = 32;

    logic        clk = 1'b0;
    logic        AXIS_ARESETN;
    logic [63:0] S_AXIS_TDATA;
    logic        S_AXIS_TLAST;
    logic        S_AXIS_TVALID;
    logic        S_AXIS_TREADY;
    logic [31:0] S_AXIS_TUSER;
    logic [63:0] M_AXIS_TDATA;
    logic        M_AXIS_TLAST;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY;
    logic [31:0] M_AXIS_TUSER;
    logic [31:0] cmd;
    logic [33:0] base_addr;
    logic [31:0] hdr_cfg;
    logic [31:0] status;

    always #5 clk = ~clk;

    srio_swrite_hello_gen #(.MAX_WORDS(MAXW)) dut (
        .AXIS_ACLK    (clk),
        .AXIS_ARESETN (AXIS_ARESETN),
        .S_AXIS_TDATA (S_AXIS_TDATA),
        .S_AXIS_TLAST (S_AXIS_TLAST),
        .S_AXIS_TVALID(S_AXIS_TVALID),
        .S_AXIS_TREADY(S_AXIS_TREADY),
        .S_AXIS_TUSER (S_AXIS_TUSER),
        .M_AXIS_TDATA (M_AXIS_TDATA),
        .M_AXIS_TLAST (M_AXIS_TLAST),
        .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TREADY(M_AXIS_TREADY),
        .M_AXIS_TUSER (M_AXIS_TUSER),
        .cmd          (cmd),
        .base_addr    (base_addr),
        .hdr_cfg      (hdr_cfg),
        .status       (status)
    );

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [63:0] part_q[$];
    logic [63:0] hdr_dut[$];
    logic [63:0] hdr_mod[$];
    logic [31:0] m_tuser;
    logic [7:0]  m_tid;
    logic [33:0] m_off;
    logic [15:0] m_pkt;
    logic        m_ovf;
    bit          armed = 1'b0;
    bit          first_beat = 1'b1;
    int          pkt_beats = 0;
    int          vectors = 0;
    int          errors = 0;
    int          p_rdy = 100;
    int          p_gap = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk_hdr(input int n);
        logic [33:0] a;
        a = base_addr + m_off;
        return {m_tid, 4'h6, 4'h0, 1'b0, hdr_cfg[9:8], hdr_cfg[10], 8'(n * 8 - 1), 2'b00, a};
    endfunction

    // Compare current outputs to the model, then advance the model across the next edge.
    always @(negedge clk) begin
        logic  e_valid, e_ready, rst, in_fire, out_fire;
        beat_t fr;
        beat_t b;
        rst     = !AXIS_ARESETN || cmd[1];
        e_valid = (exp_q.size() > 0);
        fr      = e_valid ? exp_q[0] : '0;
        e_ready = !e_valid && cmd[0] && !cmd[1];
        if (armed) begin
            chk("m_tvalid", 64'(M_AXIS_TVALID), 64'(e_valid));
            chk("m_tdata", M_AXIS_TDATA, fr.data);
            chk("m_tlast", 64'(M_AXIS_TLAST), 64'(fr.last));
            chk("m_tuser", 64'(M_AXIS_TUSER), 64'(m_tuser));
            chk("s_tready", 64'(S_AXIS_TREADY), 64'(e_ready));
            chk("status", 64'(status), 64'({14'd0, e_valid, m_ovf, m_pkt}));
        end
        in_fire  = e_ready && S_AXIS_TVALID;
        out_fire = e_valid && M_AXIS_TREADY;
        if (rst) begin
            exp_q.delete();
            part_q.delete();
            m_tuser    = '0;
            m_tid      = hdr_cfg[7:0];
            m_off      = '0;
            m_pkt      = '0;
            m_ovf      = 1'b0;
            first_beat = 1'b1;
            pkt_beats  = 0;
            armed      = 1'b1;
        end else begin
            if (out_fire) begin
                if (first_beat) begin
                    hdr_dut.push_back(M_AXIS_TDATA);
                    hdr_mod.push_back(fr.data);
                end
                first_beat = fr.last;
                pkt_beats  = fr.last ? 0 : pkt_beats + 1;
                void'(exp_q.pop_front());
                if (fr.last) m_pkt++;
            end
            if (in_fire) begin
                if (part_q.size() == 0) m_tuser = S_AXIS_TUSER;
                part_q.push_back(S_AXIS_TDATA);
                if (S_AXIS_TLAST || part_q.size() == MAXW) begin
                    if (!S_AXIS_TLAST) m_ovf = 1'b1;
                    b.data = mk_hdr(part_q.size());
                    b.last = 1'b0;
                    exp_q.push_back(b);
                    for (int i = 0; i < part_q.size(); i++) begin
                        b.data = part_q[i];
                        b.last = (i == part_q.size() - 1);
                        exp_q.push_back(b);
                    end
                    m_tid = m_tid + 8'd1;
                    m_off = m_off + 34'(part_q.size() * 8);
                    part_q.delete();
                end
            end
        end
    end

    always @(posedge clk) begin
        #1 M_AXIS_TREADY = ($urandom_range(99) < p_rdy);
    end

    task automatic send_pkt(input int n, input int last_at, input logic [31:0] tu);
        bit acc;
        int t;
        for (int i = 0; i < n; i++) begin
            while (p_gap > 0 && $urandom_range(99) < p_gap) begin
                S_AXIS_TVALID = 1'b0;
                @(posedge clk);
                #1;
            end
            S_AXIS_TDATA  = {$urandom, $urandom};
            S_AXIS_TLAST  = (i == last_at);
            S_AXIS_TUSER  = (i == 0) ? tu : $urandom;
            S_AXIS_TVALID = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                acc = S_AXIS_TREADY;
                @(posedge clk);
                #1;
                t++;
            end while (!acc && t < 3000);
            if (!acc) begin
                vectors++;
                errors++;
                $display("FAIL input_timeout: beat %0d not accepted, required accepted", i);
                S_AXIS_TVALID = 1'b0;
                return;
            end
        end
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || M_AXIS_TVALID) && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 5000) begin
            vectors++;
            errors++;
            $display("FAIL drain_timeout: output still busy, required idle");
        end
    endtask

    task automatic soft_rst();
        cmd = 32'h3;
        @(posedge clk);
        #1;
        cmd = 32'h1;
        hdr_dut.delete();
        hdr_mod.delete();
    endtask

    task automatic chk_hdr(input int idx, input logic [63:0] lit);
        if (hdr_dut.size() > idx && hdr_mod.size() > idx) begin
            chk($sformatf("hdr%0d_dut", idx), hdr_dut[idx], lit);
            chk($sformatf("hdr%0d_model", idx), hdr_mod[idx], lit);
        end else begin
            vectors++;
            errors++;
            $display("FAIL hdr%0d_missing: got %0d headers, required %0d", idx, hdr_dut.size(), idx + 1);
        end
    endtask

    initial begin
        int t;
        AXIS_ARESETN  = 1'b0;
        S_AXIS_TDATA  = '0;
        S_AXIS_TLAST  = 1'b0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TUSER  = '0;
        M_AXIS_TREADY = 1'b1;
        cmd           = 32'h1;
        base_addr     = 34'h1000;
        hdr_cfg       = 32'h205;
        repeat (3) @(posedge clk);
        #1 AXIS_ARESETN = 1'b1;
        @(negedge clk);
        chk("reset_status", 64'(status), 64'd0);
        chk("reset_tvalid", 64'(M_AXIS_TVALID), 64'd0);
        chk("reset_tdata", M_AXIS_TDATA, 64'd0);
        @(posedge clk);
        #1;

        // Single 4-word packet.
        send_pkt(4, 3, 32'hAABB);
        wait_idle();
        chk_hdr(0, 64'h056041F000001000);
        chk("pkt1_tuser", 64'(M_AXIS_TUSER), 64'h0000AABB);
        chk("pkt1_status", 64'(status), 64'h1);

        // Two back-to-back full packets.
        soft_rst();
        send_pkt(32, 31, 32'h1111);
        send_pkt(32, 31, 32'h2222);
        wait_idle();
        chk_hdr(0, 64'h05604FF000001000);
        chk_hdr(1, 64'h06604FF000001100);
        chk("b2b_status", 64'(status), 64'h2);

        // 40 words with TLAST only on the last: split at 32 with overflow.
        soft_rst();
        send_pkt(40, 39, 32'h3333);
        wait_idle();
        chk_hdr(0, 64'h05604FF000001000);
        chk_hdr(1, 64'h066043F000001100);
        chk("ovf_status", 64'(status), 64'h00010002);

        // Input disabled: ready stays low and nothing is taken.
        cmd = 32'h0;
        S_AXIS_TVALID = 1'b1;
        repeat (5) @(posedge clk);
        #1 S_AXIS_TVALID = 1'b0;
        cmd = 32'h1;

        // Random lengths, random gaps and random output stalls.
        p_rdy = 50;
        p_gap = 30;
        for (int k = 0; k < 20; k++) begin
            int n;
            n = $urandom_range(40, 1);
            send_pkt(n, n - 1, $urandom);
        end
        wait_idle();
        p_gap = 0;

        // Soft reset mid-payload.
        soft_rst();
        p_rdy = 100;
        send_pkt(6, 5, 32'h5555);
        t = 0;
        while (pkt_beats < 3 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("reach_data", 64'(pkt_beats >= 3), 64'd1);
        cmd = 32'h3;
        @(posedge clk);
        #1 cmd = 32'h1;
        @(negedge clk);
        chk("srst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
        chk("srst_status", 64'(status), 64'd0);
        @(posedge clk);
        #1;
        hdr_dut.delete();
        hdr_mod.delete();
        send_pkt(4, 3, 32'h6666);
        wait_idle();
        chk_hdr(0, 64'h056041F000001000);

        // Address wrap at 2^34.
        base_addr = 34'h3_FFFF_FFF8;
        soft_rst();
        send_pkt(1, 0, 32'h7777);
        send_pkt(1, 0, 32'h8888);
        wait_idle();
        chk_hdr(0, 64'h05604073FFFFFFF8);
        chk_hdr(1, 64'h0660407000000000);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
